// File: rtl/ram_dma_pkg.sv
// Shared definitions for the RAM copy engine: FSM encoding, register map and CTRL bit positions.
package ram_dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RD   = 3'd2,
    S_WR   = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_FILL  = 2;

endpackage

// File: rtl/ram_dma_ctr.sv
// Address/count datapath: source and destination pointers (wrapping) plus a word counter.
module ram_dma_ctr
  import ram_dma_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] src_ld,
  input  logic [ADDR_W-1:0] dst_ld,
  input  logic [ADDR_W-1:0] len_ld,
  output logic [ADDR_W-1:0] src,
  output logic [ADDR_W-1:0] dst,
  output logic [ADDR_W-1:0] src_nxt,
  output logic [ADDR_W-1:0] dst_nxt,
  output logic              zero_nxt
);

  logic [ADDR_W-1:0] cnt;

  // Pointers wrap naturally at 2^ADDR_W; zero_nxt flags that the current step retires the last word.
  assign src_nxt  = src + ADDR_W'(1);
  assign dst_nxt  = dst + ADDR_W'(1);
  assign zero_nxt = (cnt == ADDR_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src <= '0;
      dst <= '0;
      cnt <= '0;
    end else if (load) begin
      src <= src_ld;
      dst <= dst_ld;
      cnt <= len_ld;
    end else if (step) begin
      src <= src_nxt;
      dst <= dst_nxt;
      cnt <= cnt - ADDR_W'(1);
    end
  end

endmodule

// File: rtl/ram_dma.sv
// RAM-to-RAM DMA: CPU-programmed SRC/DST/LEN copy, one word per RD+WR pair while granted.
// Fill mode (CTRL bit2, constant SRC pattern, one word per cycle) exists only with RAM_DMA_FILL_EN.
module ram_dma
  import ram_dma_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic              dma_req,
  input  logic              dma_gnt,
  output logic [ADDR_W-1:0] AddrRAM,
  output logic [DATA_W-1:0] DinRAM,
  input  logic [DATA_W-1:0] DoutRAM,
  output logic              write,
  output logic              CS,
  output logic              busy,
  output logic              done
);

`ifdef RAM_DMA_FILL_EN
  localparam int SRC_W = DATA_W;
`else
  localparam int SRC_W = ADDR_W;
`endif

  state_t            state;
  logic [SRC_W-1:0]  src_r;
  logic [ADDR_W-1:0] dst_r;
  logic [ADDR_W-1:0] len_r;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W-1:0] src_nxt;
  logic [ADDR_W-1:0] dst_nxt;
  logic              zero_nxt;
  logic              ctrl_wr;
  logic              start;
  logic              abort;
  logic              unused_wdata;

  assign unused_wdata = ^cfg_wdata;

  // Abort wins over start when both bits arrive together.
  assign ctrl_wr = cfg_we && (cfg_addr == REG_CTRL);
  assign abort   = ctrl_wr && busy && cfg_wdata[CTRL_ABORT];
  assign start   = ctrl_wr && !busy && (state == S_IDLE) &&
                   cfg_wdata[CTRL_START] && !cfg_wdata[CTRL_ABORT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_r <= '0;
      dst_r <= '0;
      len_r <= '0;
    end else if (cfg_we && !busy) begin
      case (cfg_addr)
        REG_SRC: src_r <= cfg_wdata[SRC_W-1:0];
        REG_DST: dst_r <= cfg_wdata[ADDR_W-1:0];
        REG_LEN: len_r <= cfg_wdata[ADDR_W-1:0];
        default: ;
      endcase
    end
  end

`ifdef RAM_DMA_FILL_EN
  logic fill_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_r <= 1'b0;
    end else if (start) begin
      fill_r <= cfg_wdata[CTRL_FILL];
    end
  end
`endif

  ram_dma_ctr #(
    .ADDR_W(ADDR_W)
  ) u_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (start),
    .step    (state == S_WR),
    .src_ld  (src_r[ADDR_W-1:0]),
    .dst_ld  (dst_r),
    .len_ld  (len_r),
    .src     (src),
    .dst     (dst),
    .src_nxt (src_nxt),
    .dst_nxt (dst_nxt),
    .zero_nxt(zero_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      dma_req <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      CS      <= 1'b0;
      write   <= 1'b0;
      AddrRAM <= '0;
      DinRAM  <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state   <= S_IDLE;
        dma_req <= 1'b0;
        busy    <= 1'b0;
        CS      <= 1'b0;
        write   <= 1'b0;
        AddrRAM <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if (len_r == '0) begin
                state <= S_FIN;
              end else begin
                state   <= S_REQ;
                busy    <= 1'b1;
                dma_req <= 1'b1;
              end
            end
          end
          S_REQ: begin
            if (dma_gnt) begin
              CS <= 1'b1;
`ifdef RAM_DMA_FILL_EN
              if (fill_r) begin
                state   <= S_WR;
                write   <= 1'b1;
                AddrRAM <= dst;
                DinRAM  <= src_r;
              end else
`endif
              begin
                state   <= S_RD;
                write   <= 1'b0;
                AddrRAM <= src;
              end
            end
          end
          // Read data is captured straight into DinRAM, which doubles as the hold register.
          S_RD: begin
            state   <= S_WR;
            write   <= 1'b1;
            AddrRAM <= dst;
            DinRAM  <= DoutRAM;
          end
          S_WR: begin
            if (zero_nxt) begin
              state   <= S_FIN;
              busy    <= 1'b0;
              dma_req <= 1'b0;
              CS      <= 1'b0;
              write   <= 1'b0;
              AddrRAM <= '0;
            end else if (!dma_gnt) begin
              state   <= S_REQ;
              CS      <= 1'b0;
              write   <= 1'b0;
              AddrRAM <= '0;
            end else begin
`ifdef RAM_DMA_FILL_EN
              if (fill_r) begin
                AddrRAM <= dst_nxt;
              end else
`endif
              begin
                state   <= S_RD;
                write   <= 1'b0;
                AddrRAM <= src_nxt;
              end
            end
          end
          S_FIN: begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_dma.sv
// Randomized self-checking bench for ram_dma: behavioural RAM plus a word-level copy/fill model.
module tb_ram_dma;

  localparam int AW = 8;
  localparam int DW = 16;
`ifdef RAM_DMA_FILL_EN
  localparam bit FILL_ON = 1'b1;
`else
  localparam bit FILL_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_addr = 2'd0;
  logic [DW-1:0] cfg_wdata = '0;
  logic          dma_req;
  logic          dma_gnt = 1'b0;
  logic [AW-1:0] AddrRAM;
  logic [DW-1:0] DinRAM;
  logic [DW-1:0] DoutRAM;
  logic          write;
  logic          CS;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [256];
  logic [DW-1:0] ref_mem [256];
  logic          ld_we = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;

  int total = 0;
  int bad = 0;
  int n_cs = 0, n_busy = 0, n_done = 0;
  int rd_q[$];
  int wa_q[$];
  logic [DW-1:0] wd_q[$];
  int exp_rd[$];
  int exp_wa[$];
  logic [DW-1:0] exp_wd[$];

  always #5 clk = ~clk;

  ram_dma #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .dma_req  (dma_req),
    .dma_gnt  (dma_gnt),
    .AddrRAM  (AddrRAM),
    .DinRAM   (DinRAM),
    .DoutRAM  (DoutRAM),
    .write    (write),
    .CS       (CS),
    .busy     (busy),
    .done     (done)
  );

  // Behavioural RAM: combinational read while selected, write on the clock edge.
  assign DoutRAM = CS ? mem[AddrRAM] : '0;
  always @(posedge clk) begin
    if (ld_we) mem[ld_addr] = ld_data;
    else if (CS && write) mem[AddrRAM] = DinRAM;
  end

  // Bus activity log, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (CS) n_cs++;
      if (busy) n_busy++;
      if (done) n_done++;
      if (CS && !write) rd_q.push_back(int'(AddrRAM));
      if (CS && write) begin
        wa_q.push_back(int'(AddrRAM));
        wd_q.push_back(DinRAM);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int a, input logic [DW-1:0] d);
    ld_we = 1'b1;
    ld_addr = AW'(a);
    ld_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic cfg_wr(input logic [1:0] a, input logic [DW-1:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Reference: n words moved in ascending order, each reading the already-updated memory.
  task automatic model_xfer(input int s, input int d, input int n, input bit fill, input logic [DW-1:0] fv);
    exp_rd.delete();
    exp_wa.delete();
    exp_wd.delete();
    for (int i = 0; i < n; i++) begin
      int sa;
      int da;
      logic [DW-1:0] v;
      sa = (s + i) % 256;
      da = (d + i) % 256;
      v = fill ? fv : ref_mem[sa];
      if (!fill) exp_rd.push_back(sa);
      ref_mem[da] = v;
      exp_wa.push_back(da);
      exp_wd.push_back(v);
    end
  endtask

  // mode: 0 plain, 1 random grant, 2 grant gap after 2nd WR, 3 abort in 2nd RD,
  //       4 reset in 2nd WR, 5 register/start writes while busy
  task automatic xfer(input logic [DW-1:0] s, input logic [DW-1:0] d, input int n,
                      input logic [DW-1:0] ctrl, input int mode, input bit prog);
    int rd0, wr0, cs0, busy0, done0, t, lim, diffs, n_eff, exp_busy;
    bit ev, fill;
    fill = FILL_ON && ctrl[2];
    if (prog) begin
      cfg_wr(2'd0, s);
      cfg_wr(2'd1, d);
      cfg_wr(2'd2, DW'(n));
    end
    rd0 = rd_q.size();
    wr0 = wa_q.size();
    cs0 = n_cs;
    busy0 = n_busy;
    done0 = n_done;
    n_eff = (mode == 3 || mode == 4) ? 1 : n;
    model_xfer(int'(s[AW-1:0]), int'(d[AW-1:0]), n_eff, fill, s);
    cfg_wr(2'd3, ctrl);
    t = 0;
    lim = 400;
    ev = 1'b0;
    while (t < lim) begin
      @(negedge clk);
      #1;
      t++;
      if (mode == 1) dma_gnt = ($urandom_range(0, 3) != 0);
      if (!ev) begin
        case (mode)
          2: if (wa_q.size() == wr0 + 2) begin
               ev = 1'b1;
               dma_gnt = 1'b0;
               repeat (5) begin
                 @(negedge clk);
                 #1;
                 check("gap_cs", 32'(CS), 0);
               end
               dma_gnt = 1'b1;
             end
          3: if (rd_q.size() == rd0 + 2) begin
               ev = 1'b1;
               cfg_wr(2'd3, 16'h0002);
               #1;
               check("abort_busy", 32'(busy), 0);
               lim = t + 10;
             end
          4: if (wa_q.size() == wr0 + 2) begin
               ev = 1'b1;
               rst_n = 1'b0;
               #1;
               check("rst_async_out", 32'({dma_req, busy, done, CS, write, AddrRAM, DinRAM}), 0);
               @(negedge clk);
               #1;
               rst_n = 1'b1;
               lim = t + 10;
             end
          5: begin
               ev = 1'b1;
               cfg_wr(2'd0, 16'h0077);
               cfg_wr(2'd2, 16'h0033);
               cfg_wr(2'd3, 16'h0001);
             end
          default: ;
        endcase
      end
      if (n_done != done0) break;
    end
    dma_gnt = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("done_cnt", 32'(n_done - done0), (mode == 3 || mode == 4) ? 0 : 1);
    diffs = 0;
    for (int i = 0; i < exp_wa.size(); i++) begin
      if (wr0 + i >= wa_q.size()) diffs++;
      else if (wa_q[wr0 + i] != exp_wa[i] || wd_q[wr0 + i] !== exp_wd[i]) diffs++;
    end
    check("wr_seq", 32'(diffs), 0);
    diffs = 0;
    for (int i = 0; i < exp_rd.size(); i++) begin
      if (rd0 + i >= rd_q.size()) diffs++;
      else if (rd_q[rd0 + i] != exp_rd[i]) diffs++;
    end
    check("rd_seq", 32'(diffs), 0);
    if (mode != 4) check("wr_cnt", 32'(wa_q.size() - wr0), 32'(exp_wa.size()));
    if (mode != 3 && mode != 4) begin
      check("rd_cnt", 32'(rd_q.size() - rd0), 32'(exp_rd.size()));
      check("cs_cycles", 32'(n_cs - cs0), fill ? 32'(n) : 32'(2 * n));
    end
    if (mode == 0 || mode == 5) begin
      exp_busy = (n == 0) ? 0 : (fill ? n + 1 : 2 * n + 1);
      check("busy_cycles", 32'(n_busy - busy0), 32'(exp_busy));
    end
    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check("ram", 32'(diffs), 0);
  endtask

  initial begin
    int done0, cs0;
    #1;
    check("rst_out", 32'({dma_req, busy, done, CS, write, AddrRAM, DinRAM}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) poke(i, DW'($urandom));
    for (int i = 0; i < 4; i++) poke(16 + i, DW'(16'h00A0 + i));
    dma_gnt = 1'b1;

    xfer(16'h0010, 16'h0080, 4, 16'h0001, 0, 1'b1);
    xfer(16'h0010, 16'h0080, 4, 16'h0001, 5, 1'b1);
    xfer(16'h0010, 16'h0080, 4, 16'h0001, 0, 1'b0);
    xfer(16'h00FE, 16'h0001, 3, 16'h0001, 0, 1'b1);
    xfer(16'h0030, 16'h0050, 4, 16'h0001, 2, 1'b1);
    xfer(16'h0060, 16'h0070, 4, 16'h0001, 3, 1'b1);
    xfer(16'h0005, 16'h0006, 0, 16'h0001, 0, 1'b1);

    // Start and abort together in IDLE: nothing may start.
    cfg_wr(2'd2, 16'h0004);
    cs0 = n_cs;
    cfg_wr(2'd3, 16'h0003);
    repeat (3) @(negedge clk);
    #1;
    check("start_abort_busy", 32'(busy), 0);
    check("start_abort_cs", 32'(n_cs - cs0), 0);

    xfer(16'h0040, 16'h0090, 4, 16'h0001, 4, 1'b1);
    // Config registers were cleared by reset, so a bare start is a zero-length transfer.
    done0 = n_done;
    cs0 = n_cs;
    cfg_wr(2'd3, 16'h0001);
    repeat (4) @(negedge clk);
    #1;
    check("rst_cfg_done", 32'(n_done - done0), 1);
    check("rst_cfg_cs", 32'(n_cs - cs0), 0);

    xfer(16'hBEEF, 16'h0020, 8, 16'h0005, 0, 1'b1);

    for (int k = 0; k < 30; k++) begin
      logic [DW-1:0] c;
      c = 16'h0001 | (DW'($urandom_range(0, 1)) << 2);
      xfer(DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)),
           $urandom_range(0, 12), c, 1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_dma.md
RAM_DMA -- requirements
Module: ram_dma

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL be the RAM address width.
REQ-002 Parameter DATA_W, default 16, SHALL be the RAM data width.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 cfg_we  input  1  SHALL be the CPU register write strobe, sampled on posedge clk.
REQ-006 cfg_addr  input  2  SHALL select the register: 0=SRC, 1=DST, 2=LEN, 3=CTRL.
REQ-007 cfg_wdata  input  DATA_W  SHALL be the CPU register write data.
REQ-008 dma_req  output  1  SHALL request RAM bus ownership.
REQ-009 dma_gnt  input  1  SHALL be the RAM bus grant from the CPU side.
REQ-010 AddrRAM  output  ADDR_W  SHALL be the RAM address.
REQ-011 DinRAM  output  DATA_W  SHALL be the RAM write data.
REQ-012 DoutRAM  input  DATA_W  SHALL be the RAM read data, valid combinationally while CS=1.
REQ-013 write  output  1  SHALL be the RAM write enable.
REQ-014 CS  output  1  SHALL be the RAM chip select.
REQ-015 busy  output  1  SHALL be high from accepted start until the transfer completes or aborts.
REQ-016 done  output  1  SHALL be a one-cycle pulse on normal completion.

Function
REQ-017 FSM states SHALL be IDLE, REQ, RD, WR, FIN; copy of one word SHALL be RD then WR, with 2 cycles per word while granted.
REQ-018 A CTRL write with bit0=1 in IDLE SHALL load the counters from SRC[ADDR_W-1:0], DST[ADDR_W-1:0] and LEN[ADDR_W-1:0], and SHALL go to REQ with busy=1 and dma_req=1 on the next cycle.
REQ-019 A start request with LEN=0 SHALL go directly to FIN, with no RAM access, and done SHALL pulse on the cycle after FIN.
REQ-020 REQ SHALL go to RD on the first cycle in which dma_gnt=1.
REQ-021 In RD the outputs SHALL be CS=1, write=0 and AddrRAM=src; DoutRAM SHALL be captured into a hold register at the closing edge.
REQ-022 In WR the outputs SHALL be CS=1, write=1, AddrRAM=dst and DinRAM=hold; at the closing edge src and dst SHALL increment, and the count SHALL decrement.
REQ-023 After WR, the FSM SHALL go to FIN when the count reaches 0, to REQ when dma_gnt=0, and to RD otherwise.
REQ-024 dma_gnt falling during RD SHALL NOT interrupt the current word.
REQ-025 FIN SHALL pulse done, drop busy and dma_req, and return to IDLE.
REQ-026 src and dst SHALL wrap modulo 2^ADDR_W (0xFF+1=0x00).
REQ-027 Overlapping ranges SHALL be copied in ascending order, with no overlap correction.
REQ-028 In all states other than RD and WR, CS, write and AddrRAM SHALL be 0, and DinRAM SHALL hold its last value.
REQ-029 Register writes to SRC, DST and LEN while busy=1 SHALL be ignored, and a start while busy=1 SHALL be ignored.
REQ-030 A CTRL write with bit1=1 while busy=1 SHALL abort: the FSM SHALL go to IDLE next cycle, an in-progress RD SHALL NOT be followed by its WR, and done SHALL NOT pulse.
REQ-031 When bit0 and bit1 are set in the same CTRL write, abort SHALL take priority.

Reset
REQ-032 rst_n=0 SHALL immediately force state IDLE and clear every output, counter, hold and config register.
REQ-033 Reset mid-transfer SHALL abandon the transfer with no further RAM write.

Configuration
REQ-034 With RAM_DMA_FILL_EN defined, CTRL bit2=1 at start SHALL select fill mode: RD SHALL be skipped and each WR SHALL write SRC[DATA_W-1:0], giving 1 word per cycle while granted.
REQ-035 Without RAM_DMA_FILL_EN, CTRL bit2 SHALL be ignored, and no fill logic SHALL exist.

Structure
REQ-036 Package ram_dma_pkg SHALL hold the FSM state encoding, the register offsets (SRC/DST/LEN/CTRL) and the CTRL bit positions.
REQ-037 The address/count datapath SHALL be the sub-module ram_dma_ctr (load, increment, wrap, zero flag); the FSM SHALL stay in ram_dma.

Verification
REQ-038 Copy test: preload RAM[0x10..0x13]=A0..A3, SRC=0x10, DST=0x80, LEN=4, gnt tied 1, start -> RAM[0x80..0x83]=A0..A3, busy high 9 cycles, one done pulse.
REQ-039 Wrap test: SRC=0xFE, DST=0x01, LEN=3 -> reads 0xFE, 0xFF, 0x00 and writes 0x01..0x03.
REQ-040 Grant test: drop dma_gnt after the 2nd WR of LEN=4 for 5 cycles -> CS=0 throughout the gap, the transfer resumes with the 3rd word, and the final data is correct.
REQ-041 Abort/LEN0 test: abort during the 2nd RD -> only 1 word written and no done; LEN=0 start -> done with zero CS cycles.
REQ-042 Reset test: rst_n low mid-WR -> all outputs 0 asynchronously, and the RAM holds only the words completed before reset.
REQ-043 Fill test (RAM_DMA_FILL_EN): SRC=0xBEEF, DST=0x20, LEN=8, bit2=1 -> RAM[0x20..0x27]=0xBEEF in 8 WR cycles.
